fft_peak_detect: RTL
====================

// Module: fft_peak_detect
// PURPOSE
//   Consumer end of the FFT result interface. Captures each 16-bin frame on fft_valid
//   (each bin = {real[15:0], imag[15:0]}, two's complement). Scans the bins one per
//   clock, computing re^2+im^2, and reports the dominant frequency bin and its power.
//   Sits after the FFT stage; its output is the frequency-analysis result.
// PARAMETERS
//   N_BINS   16  bins per frame (fixed; index width 4)
//   HALF_EN  0   1: scan only bins 0..N_BINS/2-1 (real-input spectrum); 0: all bins
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    reset, asynchronous, active-high
//   fft_valid  in   1    1-cycle strobe; fft_d0..fft_d15 are valid in that cycle
//   fft_d0..15 in   32   bin k: [31:16] real, [15:0] imag, signed
//   done       out  1    1-cycle pulse; freq/peak_pow are valid from this cycle
//   freq       out  4    index of max-power bin; held until the next done
//   peak_pow   out  32   unsigned re^2+im^2 of that bin; held until the next done
//   busy       out  1    high while in SCAN or while the pending buffer is full
//   overrun    out  1    1-cycle pulse when a frame is dropped
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; idx 0; pend_vld 0; best_pow 0; best_idx 0.
//   States: IDLE, SCAN. Edge counts are relative to the capture edge E0.
//   IDLE: fft_valid=1 at edge E0 -> load work buffer, set idx=0, best_pow=0,
//     best_idx=0, go to SCAN.
//   SCAN: on edges E1..E16, process bin idx=0..15, one bin per edge.
//     - p = re*re + im*im, using signed 16x16 products.
//     - Result width is 32-bit unsigned with no saturation needed:
//       max is 2*(-32768)^2 = 2^31.
//     - Update the best bin only on strict p > best_pow, so the lowest index wins ties.
//     - A bin 0 with p=0 still yields best_idx=0.
//   HALF_EN=1: the last bin is 7, so done comes at E8.
//   Last-bin edge (E16):
//     - Drive done<=1, freq<=final best_idx, peak_pow<=final best_pow.
//     - The compare result of the last bin is included.
//     - If pend_vld: load pending into work, clear pend_vld, restart SCAN at idx=0.
//     - Else if fft_valid=1 this edge: load the inputs into work, restart SCAN.
//     - Else go to IDLE.
//   Latency: fft_valid at E0 -> done high during the cycle after E16 (16 clocks).
//     This is back-to-back capable at the upstream minimum frame spacing of 16 clocks.
//   fft_valid during SCAN, not on the last-bin edge:
//     - pend_vld=0: copy the inputs to the pending buffer, set pend_vld=1.
//     - pend_vld=1: drop the new frame, pulse overrun; the pending frame is kept.
//   Last-bin edge with pend_vld=1 and fft_valid=1:
//     - Pending moves to work.
//     - The new inputs go to pending; no overrun.
//   done and overrun are single-cycle pulses. Otherwise they are 0.
//   busy = (state==SCAN) | pend_vld, registered.
//   rst mid-scan: the frame is abandoned with no done pulse, pending is cleared,
//     and freq/peak_pow return to 0.
// STRUCTURE
//   Package fft_pkg:
//     - N_BINS, BIN_W=16, POW_W=32, IDX_W=4.
//     - Functions bin_re(w)=w[31:16] and bin_im(w)=w[15:0].
//   Sub-module cplx_pow_sq (combinational): in re,im [15:0] signed; out pow [31:0].
//   Top contents:
//     - 16x32 work and pending register files.
//     - 4-bit idx counter and 2-state FSM.
//     - 16:1 bin mux into cplx_pow_sq, then the compare/update registers.
// TESTING
//   1. Single tone: bin3 = {16'h0100,16'h0000}, all others 0.
//      -> done 16 clocks after fft_valid; freq=3; peak_pow=32'h00010000.
//   2. Tie: bin2 = {0,16'h0080} and bin9 = {16'h0080,0}.
//      -> freq=2, peak_pow=32'h00004000; lowest index wins.
//   3. Extremes: bin15 = {16'h8000,16'h8000}, bin0 = {16'h7FFF,0}.
//      -> freq=15, peak_pow=32'h80000000; no overflow.
//   4. Back-to-back frames 16 clocks apart (peaks at bins 5, then 11).
//      -> done pulses exactly 16 clocks apart; freq 5 then 11; overrun never pulses.
//   5. Three frames at clocks 0, 2, 4 (peaks 1, 6, 12).
//      -> overrun at clock 4; done pulses report 1 then 6; frame 12 is never reported.
//   6. rst asserted at scan bin 8 with a pending frame.
//      -> outputs 0 immediately; no done; the next fft_valid reports correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths and bin field helpers for the FFT result consumer.
`default_nettype none

package fft_pkg;
  localparam int N_BINS = 16;
  localparam int BIN_W  = 16;
  localparam int POW_W  = 32;
  localparam int IDX_W  = 4;

  function automatic logic signed [BIN_W-1:0] bin_re(input logic [2*BIN_W-1:0] w);
    return w[2*BIN_W-1:BIN_W];
  endfunction

  function automatic logic signed [BIN_W-1:0] bin_im(input logic [2*BIN_W-1:0] w);
    return w[BIN_W-1:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/cplx_pow_sq.sv
// cplx_pow_sq: combinational re^2 + im^2 of one signed complex bin.
`default_nettype none

module cplx_pow_sq
  import fft_pkg::*;
(
  input  logic signed [BIN_W-1:0] re,
  input  logic signed [BIN_W-1:0] im,
  output logic        [POW_W-1:0] pow
);
  logic signed [POW_W-1:0] re_x, im_x, re_sq, im_sq;

  assign re_x  = {{(POW_W-BIN_W){re[BIN_W-1]}}, re};
  assign im_x  = {{(POW_W-BIN_W){im[BIN_W-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  // Each square is at most 2^30, so the unsigned sum peaks at exactly 2^31.
  assign pow   = unsigned'(re_sq) + unsigned'(im_sq);
endmodule

`default_nettype wire

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: captures 16-bin FFT frames and scans one bin per clock for the
// maximum-power bin, with a single-frame pending buffer for back-to-back arrivals.
`default_nettype none

module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int HALF_EN = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fft_valid,
  input  logic [2*BIN_W-1:0] fft_d0,
  input  logic [2*BIN_W-1:0] fft_d1,
  input  logic [2*BIN_W-1:0] fft_d2,
  input  logic [2*BIN_W-1:0] fft_d3,
  input  logic [2*BIN_W-1:0] fft_d4,
  input  logic [2*BIN_W-1:0] fft_d5,
  input  logic [2*BIN_W-1:0] fft_d6,
  input  logic [2*BIN_W-1:0] fft_d7,
  input  logic [2*BIN_W-1:0] fft_d8,
  input  logic [2*BIN_W-1:0] fft_d9,
  input  logic [2*BIN_W-1:0] fft_d10,
  input  logic [2*BIN_W-1:0] fft_d11,
  input  logic [2*BIN_W-1:0] fft_d12,
  input  logic [2*BIN_W-1:0] fft_d13,
  input  logic [2*BIN_W-1:0] fft_d14,
  input  logic [2*BIN_W-1:0] fft_d15,
  output logic               done,
  output logic [IDX_W-1:0]   freq,
  output logic [POW_W-1:0]   peak_pow,
  output logic               busy,
  output logic               overrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    (HALF_EN != 0) ? IDX_W'(N_BINS/2 - 1) : IDX_W'(N_BINS - 1);

  logic [0:0]         state, state_n;
  logic [IDX_W-1:0]   idx, best_idx;
  logic [POW_W-1:0]   best_pow, pow;
  logic               pend_vld, pend_vld_n;
  logic               last, scanning, better;
  logic               ld_work_in, ld_work_pend, ld_pend, ovr_n;
  logic [2*BIN_W-1:0] din  [N_BINS];
  logic [2*BIN_W-1:0] work [N_BINS];
  logic [2*BIN_W-1:0] pend [N_BINS];

  assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                 fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  cplx_pow_sq u_pow (
    .re  (bin_re(work[idx])),
    .im  (bin_im(work[idx])),
    .pow (pow)
  );

  assign scanning = (state == SCAN);
  assign last     = scanning && (idx == LAST_IDX);
  assign better   = pow > best_pow;

  always_comb begin
    ld_work_in   = fft_valid && (!scanning || (last && !pend_vld));
    ld_work_pend = last && pend_vld;
    // On the last-bin edge the pending slot frees up, so a new frame refills it.
    ld_pend      = fft_valid && scanning && (last ? pend_vld : !pend_vld);
    ovr_n        = fft_valid && scanning && !last && pend_vld;
    pend_vld_n   = pend_vld;
    if (ld_pend)
      pend_vld_n = 1'b1;
    else if (ld_work_pend)
      pend_vld_n = 1'b0;
    state_n = state;
    if (!scanning)
      state_n = fft_valid ? SCAN : IDLE;
    else if (last)
      state_n = (pend_vld || fft_valid) ? SCAN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (ld_work_in)
      work <= din;
    else if (ld_work_pend)
      work <= pend;
    if (ld_pend)
      pend <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pend_vld <= 1'b0;
      best_pow <= '0;
      best_idx <= '0;
      done     <= 1'b0;
      freq     <= '0;
      peak_pow <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      pend_vld <= pend_vld_n;
      busy     <= (state_n == SCAN) || pend_vld_n;
      overrun  <= ovr_n;
      done     <= 1'b0;
      if (scanning && !last) begin
        idx <= idx + 1'b1;
        if (better) begin
          best_pow <= pow;
          best_idx <= idx;
        end
      end else begin
        if (last) begin
          done     <= 1'b1;
          freq     <= better ? idx : best_idx;
          peak_pow <= better ? pow : best_pow;
        end
        idx      <= '0;
        best_pow <= '0;
        best_idx <= '0;
      end
    end
  end
endmodule

`default_nettype wire
